// File: rtl/wave_meas.sv
// wave_meas: receive-side measurement of an 8-bit sample stream.
// Detects rising threshold crossings with hysteresis. For each waveform period
// it reports the period length, the high time and the min/max sample. The
// threshold follows the signal midpoint, and no_signal is raised on a timeout.
//
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   sample_in   8-bit sample, taken every clock
//   period_out  clocks between the last two rising crossings
//   high_out    clocks at level high within that period
//   min_out     minimum sample seen in that period
//   max_out     maximum sample seen in that period
//   meas_valid  one-cycle pulse when the four result outputs update
//   no_signal   sticky timeout flag, cleared by the next meas_valid
//   locked      high while measuring (a crossing has been seen)
module wave_meas #(
    parameter int unsigned THR_INIT = 128,
    parameter int unsigned HYST     = 8,
    parameter int unsigned TIMEOUT  = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sample_in,
    output logic [31:0] period_out,
    output logic [31:0] high_out,
    output logic [7:0]  min_out,
    output logic [7:0]  max_out,
    output logic        meas_valid,
    output logic        no_signal,
    output logic        locked
);

    localparam int unsigned SW = 8;
    localparam int unsigned CW = 32;
    localparam logic [SW:0]   HYST9   = (SW+1)'(HYST);
    localparam logic [SW:0]   SWING9  = (SW+1)'(2 * HYST);
    localparam logic [SW-1:0] THR_RST = SW'(THR_INIT);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {ACQUIRE = 1'b0, MEASURE = 1'b1} state_e;

    state_e         state_q, state_d;
    logic [SW-1:0]  s_q;
    logic           vld_q;
    logic           lvl_q, lvl_d;
    logic [SW-1:0]  thr_q, thr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  hcnt_q, hcnt_d;
    logic [SW-1:0]  rmin_q, rmin_d, rmax_q, rmax_d;
    logic [CW-1:0]  period_q, period_d, high_q, high_d;
    logic [SW-1:0]  min_q, min_d, max_q, max_d;
    logic           mvalid_q, mvalid_d, nosig_q, nosig_d, locked_q, locked_d;

    logic [SW:0]    hi_sum, lo_dif, mid_sum, swing;
    logic [SW-1:0]  hi_thr, lo_thr, mid, trk_min, trk_max;
    logic           rise, fall, lvl_nx, timeout, swing_ok;

    // Clamped hysteresis thresholds and level detector
    always_comb begin
        hi_sum  = {1'b0, thr_q} + HYST9;
        lo_dif  = {1'b0, thr_q} - HYST9;
        hi_thr  = hi_sum[SW] ? {SW{1'b1}} : hi_sum[SW-1:0];
        lo_thr  = lo_dif[SW] ? {SW{1'b0}} : lo_dif[SW-1:0];
        rise    = !lvl_q && (s_q >= hi_thr);
        fall    = lvl_q && (s_q <= lo_thr);
        lvl_nx  = rise ? 1'b1 : (fall ? 1'b0 : lvl_q);
        timeout = !rise && (cnt_q == TO_LAST);
    end

    // Window midpoint and swing; the reset-time s_q is not a real sample, so vld_q gates tracking
    always_comb begin
        mid_sum  = {1'b0, rmax_q} + {1'b0, rmin_q};
        mid      = mid_sum[SW:1];
        swing    = {1'b0, rmax_q} - {1'b0, rmin_q};
        swing_ok = (rmax_q > rmin_q) && (swing > SWING9);
        trk_min  = (vld_q && (s_q < rmin_q)) ? s_q : rmin_q;
        trk_max  = (vld_q && (s_q > rmax_q)) ? s_q : rmax_q;
    end

    // Next-state and result logic
    always_comb begin
        state_d  = state_q;
        lvl_d    = lvl_nx;
        thr_d    = thr_q;
        cnt_d    = cnt_q + CW'(1);
        hcnt_d   = hcnt_q;
        rmin_d   = trk_min;
        rmax_d   = trk_max;
        period_d = period_q;
        high_d   = high_q;
        min_d    = min_q;
        max_d    = max_q;
        mvalid_d = 1'b0;
        nosig_d  = nosig_q;
        if (rise) begin
            // The rise cycle opens a new period
            state_d = MEASURE;
            cnt_d   = CW'(1);
            hcnt_d  = CW'(1);
            rmin_d  = s_q;
            rmax_d  = s_q;
            if (state_q == MEASURE) begin
                period_d = cnt_q;
                high_d   = hcnt_q;
                min_d    = rmin_q;
                max_d    = rmax_q;
                mvalid_d = 1'b1;
                nosig_d  = 1'b0;
                thr_d    = mid;
            end
        end else if (timeout) begin
            state_d = ACQUIRE;
            nosig_d = 1'b1;
            cnt_d   = '0;
            hcnt_d  = '0;
            lvl_d   = 1'b0;
            rmin_d  = s_q;
            rmax_d  = s_q;
            thr_d   = swing_ok ? mid : THR_RST;
        end else if (state_q == MEASURE) begin
            hcnt_d = hcnt_q + CW'(lvl_nx);
        end
        locked_d = (state_d == MEASURE);
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACQUIRE;
            s_q      <= '0;
            vld_q    <= 1'b0;
            lvl_q    <= 1'b0;
            thr_q    <= THR_RST;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            rmin_q   <= {SW{1'b1}};
            rmax_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            min_q    <= '0;
            max_q    <= '0;
            mvalid_q <= 1'b0;
            nosig_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= sample_in;
            vld_q    <= 1'b1;
            lvl_q    <= lvl_d;
            thr_q    <= thr_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            rmin_q   <= rmin_d;
            rmax_q   <= rmax_d;
            period_q <= period_d;
            high_q   <= high_d;
            min_q    <= min_d;
            max_q    <= max_d;
            mvalid_q <= mvalid_d;
            nosig_q  <= nosig_d;
            locked_q <= locked_d;
        end
    end

    assign period_out = period_q;
    assign high_out   = high_q;
    assign min_out    = min_q;
    assign max_out    = max_q;
    assign meas_valid = mvalid_q;
    assign no_signal  = nosig_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_wave_meas.sv
// tb_wave_meas: directed scenarios with a scoreboard of expected measurements.
// u_dut uses TIMEOUT=64; u_long (TIMEOUT=1000) runs the 100-sample sine.
module tb_wave_meas;

    localparam real PI = 3.14159265358979;

    logic        clk;
    logic        rst;
    logic [7:0]  sample_in;

    logic [31:0] a_period, a_high, b_period, b_high;
    logic [7:0]  a_min, a_max, b_min, b_max;
    logic        a_valid, a_nosig, a_locked, b_valid, b_nosig, b_locked;

    int sel;
    logic [31:0] m_period, m_high;
    logic [7:0]  m_min, m_max;
    logic        m_valid, m_nosig, m_locked;

    assign m_period = (sel == 1) ? b_period : a_period;
    assign m_high   = (sel == 1) ? b_high   : a_high;
    assign m_min    = (sel == 1) ? b_min    : a_min;
    assign m_max    = (sel == 1) ? b_max    : a_max;
    assign m_valid  = (sel == 1) ? b_valid  : a_valid;
    assign m_nosig  = (sel == 1) ? b_nosig  : a_nosig;
    assign m_locked = (sel == 1) ? b_locked : a_locked;

    wave_meas #(.THR_INIT(128), .HYST(8), .TIMEOUT(64)) u_dut (
        .clk(clk), .rst(rst), .sample_in(sample_in),
        .period_out(a_period), .high_out(a_high), .min_out(a_min), .max_out(a_max),
        .meas_valid(a_valid), .no_signal(a_nosig), .locked(a_locked)
    );

    wave_meas #(.THR_INIT(128), .HYST(8), .TIMEOUT(1000)) u_long (
        .clk(clk), .rst(rst), .sample_in(sample_in),
        .period_out(b_period), .high_out(b_high), .min_out(b_min), .max_out(b_max),
        .meas_valid(b_valid), .no_signal(b_nosig), .locked(b_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int at;   // step index where meas_valid is due, -1 = not checked
        int per;
        int hlo;
        int hhi;
        int mn;
        int mx;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;
    int   idx;
    logic [7:0] tri_rom [28];
    logic [7:0] sin_rom [100];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_rng(input string tag, input logic [63:0] obs, input int lo, input int hi);
        total++;
        assert (obs >= 64'(lo) && obs <= 64'(hi)) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic push(input int at, input int per, input int hlo, input int hhi,
                        input int mn, input int mx);
        exp_t e;
        e.at = at; e.per = per; e.hlo = hlo; e.hhi = hhi; e.mn = mn; e.mx = mx;
        exp_q.push_back(e);
    endtask

    // Drive one sample, clock it, then compare any measurement against the scoreboard
    task automatic step(input logic [7:0] s);
        exp_t e;
        sample_in = s;
        @(posedge clk);
        #1;
        if (m_valid === 1'b1) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL spurious_valid observed=1 expected=0 at idx=%0d", idx);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.at >= 0) chk("valid_idx", 64'(idx), 64'(e.at));
                chk("period", 64'(m_period), 64'(e.per));
                chk_rng("high", 64'(m_high), e.hlo, e.hhi);
                chk("min", 64'(m_min), 64'(e.mn));
                chk("max", 64'(m_max), 64'(e.mx));
                chk("nosig_clear", 64'(m_nosig), 64'(0));
            end
        end
        idx++;
    endtask

    task automatic do_reset(input int s);
        sel       = s;
        rst       = 1'b1;
        sample_in = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_period", 64'(m_period), 64'(0));
        chk("rst_high",   64'(m_high),   64'(0));
        chk("rst_minmax", 64'({m_min, m_max}), 64'(0));
        chk("rst_valid",  64'(m_valid),  64'(0));
        chk("rst_nosig",  64'(m_nosig),  64'(0));
        chk("rst_locked", 64'(m_locked), 64'(0));
        chk("rst_thr",    64'(u_dut.thr_q), 64'(128));
        rst = 1'b0;
        idx = 0;
        exp_q.delete();
    endtask

    function automatic logic [7:0] sq(input int i);
        return ((i % 20) < 10) ? 8'd0 : 8'd255;
    endfunction

    function automatic logic [7:0] pwm(input int i);
        return ((i % 20) < 5) ? 8'd255 : 8'd128;
    endfunction

    initial begin
        int mn;
        int mx;
        total = 0;
        bad   = 0;
        idx   = 0;
        sel   = 0;
        rst   = 1'b1;
        sample_in = 8'd0;
        // Triangle 100..156 step 4 with +-6 spikes near 128 (indices 7, 8, 9, 22)
        tri_rom = '{8'd100, 8'd104, 8'd108, 8'd112, 8'd116, 8'd120, 8'd124, 8'd122,
                    8'd138, 8'd130, 8'd140, 8'd144, 8'd148, 8'd152, 8'd156, 8'd152,
                    8'd148, 8'd144, 8'd140, 8'd136, 8'd132, 8'd128, 8'd130, 8'd120,
                    8'd116, 8'd112, 8'd108, 8'd104};
        mn = 255;
        mx = 0;
        for (int i = 0; i < 100; i++) begin
            real r;
            r = 128.0 + 127.0 * $sin(2.0 * PI * i / 100.0);
            sin_rom[i] = 8'($rtoi(r + 0.5));
            if (int'(sin_rom[i]) < mn) mn = int'(sin_rom[i]);
            if (int'(sin_rom[i]) > mx) mx = int'(sin_rom[i]);
        end

        // Square 10x0 / 10x255: rise at 10, first result at step 31, then every 20
        do_reset(0);
        for (int i = 0; i < 100; i++) begin
            if (i % 20 == 10 && i >= 30) push(i + 1, 20, 10, 10, 0, 255);
            step(sq(i));
        end
        chk("sq_thr", 64'(u_dut.thr_q), 64'(127));
        chk("sq_locked", 64'(m_locked), 64'(1));
        chk("sq_pending", 64'(exp_q.size()), 64'(0));

        // PWM 5x255 / 15x128: lo_thr 120 never reached, timeout at step 64, thr 191,
        // relock at sample 64 gives a 16-clock first period, then 20/5
        do_reset(0);
        for (int i = 0; i < 140; i++) begin
            if (i == 80) push(81, 16, 1, 1, 128, 255);
            if (i == 100 || i == 120) push(i + 1, 20, 5, 5, 128, 255);
            step(pwm(i));
            if (i == 63) chk("pwm_nosig_pre", 64'(m_nosig), 64'(0));
            if (i == 64) begin
                chk("pwm_nosig_set", 64'(m_nosig), 64'(1));
                chk("pwm_unlocked", 64'(m_locked), 64'(0));
                chk("pwm_thr", 64'(u_dut.thr_q), 64'(191));
            end
        end
        chk("pwm_pending", 64'(exp_q.size()), 64'(0));

        // Constant 50: no measurements, timeout at step 63, threshold stays 128
        do_reset(0);
        for (int i = 0; i < 140; i++) begin
            step(8'd50);
            if (i == 62) chk("const_nosig_pre", 64'(m_nosig), 64'(0));
            if (i == 63) begin
                chk("const_nosig_set", 64'(m_nosig), 64'(1));
                chk("const_thr", 64'(u_dut.thr_q), 64'(128));
            end
        end
        chk("const_nosig_end", 64'(m_nosig), 64'(1));
        chk("const_locked", 64'(m_locked), 64'(0));

        // Noisy triangle: one rise per period (at index 8), period 28, high 15
        do_reset(0);
        for (int i = 0; i < 140; i++) begin
            if (i % 28 == 8 && i >= 36) push(i + 1, 28, 15, 15, 100, 156);
            step(tri_rom[i % 28]);
        end
        chk("tri_pending", 64'(exp_q.size()), 64'(0));

        // Sine ROM on the long-timeout instance
        do_reset(1);
        for (int i = 0; i < 320; i++) begin
            if (i == 100 || i == 200 || i == 300) push(-1, 100, 48, 52, mn, mx);
            step(sin_rom[i % 100]);
        end
        chk("sine_pending", 64'(exp_q.size()), 64'(0));

        // Reset one cycle after the rise at sample 50: the pending result is dropped
        do_reset(0);
        for (int i = 0; i <= 50; i++) begin
            if (i == 30) push(31, 20, 10, 10, 0, 255);
            step(sq(i));
        end
        rst = 1'b1;
        step(sq(51));
        rst = 1'b0;
        chk("mid_rst_valid",  64'(m_valid),  64'(0));
        chk("mid_rst_locked", 64'(m_locked), 64'(0));
        chk("mid_rst_period", 64'(m_period), 64'(0));
        chk("mid_rst_high",   64'(m_high),   64'(0));
        chk("mid_rst_max",    64'(m_max),    64'(0));
        for (int i = 52; i < 96; i++) begin
            if (i == 70) push(71, 18, 8, 8, 0, 255);
            if (i == 90) push(91, 20, 10, 10, 0, 255);
            step(sq(i));
            if (i == 60) chk("mid_rst_relock", 64'(m_locked), 64'(1));
        end
        chk("mid_rst_pending", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_meas.md
Name: wave_meas

Overview:
- Receive-side measurement block for the function generator's 8-bit sample stream; sits on the loopback or capture path.
- Takes one sample per clock and detects rising threshold crossings with hysteresis.
- Per waveform period, reports period length, high time, minimum and maximum sample.
- Adapts its threshold to the signal midpoint and flags loss of signal after a timeout.

Parameters:
THR_INIT, 128, threshold used after reset and after a timeout with insufficient swing
HYST, 8, hysteresis half-width in LSBs
TIMEOUT, 1000000, clocks without a rising crossing before no_signal is raised (1 to 2^32-1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
sample_in  input  8  waveform sample, taken every clock
period_out  output  32  clocks between the last two rising crossings
high_out  output  32  clocks at level high within that period
min_out  output  8  minimum sample in that period
max_out  output  8  maximum sample in that period
meas_valid  output  1  one-cycle pulse when all four result outputs update
no_signal  output  1  sticky flag: timeout expired; cleared by the next meas_valid
locked  output  1  high while in MEASURE

Behaviour:
- Reset values: all outputs 0, s_q=0, lvl=0, thr=THR_INIT, cnt=0, state=ACQUIRE.
- Reset mid-operation discards the partial period; no meas_valid is emitted.
- Input stage: s_q <= sample_in; all logic below operates on s_q.
- Thresholds, 9-bit arithmetic:
  - hi_thr = min(thr+HYST, 255).
  - lo_thr = max(thr-HYST, 0).
- Level detector:
  - lvl=0 and s_q >= hi_thr: lvl_nx=1, rise=1.
  - lvl=1 and s_q <= lo_thr: lvl_nx=0.
  - Otherwise lvl_nx=lvl.
- Window trackers run in both states:
  - run_min/run_max include s_q every cycle.
  - On rise or timeout they reload with s_q.
- ACQUIRE:
  - cnt increments every cycle.
  - On rise: go to MEASURE, cnt<=1, hcnt<=1, trackers reload.
- MEASURE:
  - Each cycle without rise: cnt<=cnt+1, hcnt<=hcnt+lvl_nx.
  - On rise: period_out<=cnt, high_out<=hcnt, min_out<=run_min, max_out<=run_max, meas_valid<=1, no_signal<=0.
  - Also on rise: thr<=(run_max+run_min)>>1, then cnt<=1, hcnt<=1, trackers reload.
  - The rise cycle is the first cycle of the new period.
- Timeout: cnt==TIMEOUT-1 without rise, in either state.
  - State goes to ACQUIRE; no_signal<=1; cnt<=0; lvl<=0.
  - If run_max-run_min > 2*HYST: thr<=(run_max+run_min)>>1. Otherwise thr<=THR_INIT.
  - Rise has priority over timeout in the same cycle.
- Latency: meas_valid is asserted 2 clocks after the crossing sample is presented on sample_in.
- Result outputs hold between meas_valid pulses.
- cnt never wraps, because timeout precedes 2^32.
- thr changes take effect for comparisons from the following cycle.

Test Plan:
- Square wave, 10×0 then 10×255, repeated:
  - First meas_valid comes one period after the first rise, then every 20 clocks.
  - period_out=20, high_out=10, min_out=0, max_out=255; thr becomes 127.
- PWM, 5×255 then 15×128, TIMEOUT=64:
  - Initial lo_thr=120 is never reached, so no meas_valid occurs.
  - no_signal=1 at clock 64; thr becomes 191.
  - After relock: period_out=20, high_out=5, and no_signal clears on the first meas_valid.
- Constant input 50:
  - meas_valid never pulses.
  - no_signal rises after TIMEOUT clocks; thr stays 128.
- Hysteresis: triangle 100..156 step 4 with noise spikes ±6 near 128:
  - Exactly one rise per period.
  - period_out equals the triangle period; min_out=100, max_out=156.
- Sine 100-point ROM sequence, one sample per clock:
  - period_out=100; high_out within 48..52.
  - min/max match the ROM extremes.
- Reset mid-MEASURE (rst high 1 cycle):
  - All outputs return to 0, and locked=0 the cycle after.
  - No stale meas_valid is emitted.
  - The next valid result appears after two new rises.
